// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: FSM state encoding, S-box geometry, timing defaults and key-byte helper.
// Used by both the key-scheduling and PRGA/decrypt stages.
package rc4_pkg;

  localparam int unsigned S_SIZE         = 256;
  localparam int unsigned DEF_KEY_LEN    = 3;
  localparam int unsigned DEF_READ_WAIT  = 2;
  localparam int unsigned DEF_WRITE_HOLD = 2;
  localparam int unsigned SEQ_CNT_W      = 4;
  localparam int unsigned KEY_MAX_BITS   = 256;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INIT_WR,
    ST_SH_RD_I,
    ST_SH_CALC,
    ST_SH_RD_J,
    ST_SH_WR_J,
    ST_SH_WR_I,
    ST_SH_NEXT,
    ST_DONE
  } rc4_state_e;

  // Byte idx of an n_bytes-long key held MSB-first (byte 0 in the top bits).
  function automatic logic [7:0] key_byte(input logic [KEY_MAX_BITS-1:0] key,
                                          input int unsigned             n_bytes,
                                          input int unsigned             idx);
    return 8'(key >> (8 * (n_bytes - 1 - idx)));
  endfunction

endpackage

// File: rtl/rc4_mem_seq.sv
// Memory transaction pacer: counts cycles of a read-wait or write-hold window and
// acknowledges on the last cycle of the window.
module rc4_mem_seq
  import rc4_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_en,
  input  logic [SEQ_CNT_W-1:0] i_len,
  output logic                 o_ack_c
);

  logic [SEQ_CNT_W-1:0] r_cnt;

  assign o_ack_c = i_en && (r_cnt == i_len - SEQ_CNT_W'(1));

  // Counter restarts after every ack so back-to-back transactions stay aligned.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_en || o_ack_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + SEQ_CNT_W'(1);
    end
  end

endmodule

// File: rtl/rc4_ksa.sv
// RC4 key-scheduling engine: fills S with the identity, then shuffles it with the key
// through the shared 256x8 S-memory port, pulsing t_done when S is ready for the PRGA stage.
module rc4_ksa
  import rc4_pkg::*;
#(
  parameter int unsigned KEY_LEN    = DEF_KEY_LEN,
  parameter int unsigned READ_WAIT  = DEF_READ_WAIT,
  parameter int unsigned WRITE_HOLD = DEF_WRITE_HOLD
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sig_start,
  input  logic [8*KEY_LEN-1:0] secret_key,
  input  logic [7:0]           mem_out,
  output logic [7:0]           mem_address,
  output logic [7:0]           mem_data,
  output logic                 wren,
  output logic                 busy,
  output logic                 t_done
);

  localparam int unsigned          KIDX_W    = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
  localparam logic [7:0]           LAST_IDX  = 8'(S_SIZE - 1);
  localparam logic [SEQ_CNT_W-1:0] RD_LEN    = SEQ_CNT_W'(READ_WAIT + 1);
  localparam logic [SEQ_CNT_W-1:0] WR_LEN    = SEQ_CNT_W'(WRITE_HOLD);
  localparam logic [KIDX_W-1:0]    KIDX_LAST = KIDX_W'(KEY_LEN - 1);

  rc4_state_e           r_state, w_state_nxt;
  logic [7:0]           r_i, r_j, r_si, r_sj;
  logic [7:0]           w_i_nxt, w_j_nxt, w_si_nxt, w_sj_nxt;
  logic [KIDX_W-1:0]    r_kidx, w_kidx_nxt;
  logic [7:0]           w_key_byte;
  logic                 w_seq_en, w_ack;
  logic [SEQ_CNT_W-1:0] w_seq_len;
  logic [7:0]           r_mem_address, r_mem_data, w_addr_nxt, w_data_nxt;
  logic                 r_wren, r_busy, r_t_done;
  logic                 w_wren_nxt, w_busy_nxt, w_t_done_nxt;

  assign w_key_byte = key_byte(KEY_MAX_BITS'(secret_key), KEY_LEN, 32'(r_kidx));

  assign w_seq_en  = (r_state == ST_INIT_WR) || (r_state == ST_SH_RD_I) ||
                     (r_state == ST_SH_RD_J) || (r_state == ST_SH_WR_J) ||
                     (r_state == ST_SH_WR_I);
  assign w_seq_len = ((r_state == ST_SH_RD_I) || (r_state == ST_SH_RD_J)) ? RD_LEN : WR_LEN;

  rc4_mem_seq u_mem_seq (
    .clk     (clk),
    .reset   (reset),
    .i_en    (w_seq_en),
    .i_len   (w_seq_len),
    .o_ack_c (w_ack)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus next datapath values (i, j, kidx, S[i], S[j]).
  always_comb begin
    w_state_nxt = r_state;
    w_i_nxt     = r_i;
    w_j_nxt     = r_j;
    w_si_nxt    = r_si;
    w_sj_nxt    = r_sj;
    w_kidx_nxt  = r_kidx;
    case (r_state)
      ST_IDLE: begin
        if (sig_start) begin
          w_state_nxt = ST_INIT_WR;
          w_i_nxt     = '0;
          w_j_nxt     = '0;
          w_kidx_nxt  = '0;
        end
      end
      ST_INIT_WR: begin
        if (w_ack) begin
          w_i_nxt = r_i + 8'd1;
          if (r_i == LAST_IDX) begin
            w_state_nxt = ST_SH_RD_I;
          end
        end
      end
      ST_SH_RD_I: begin
        if (w_ack) begin
          w_si_nxt    = mem_out;
          w_state_nxt = ST_SH_CALC;
        end
      end
      ST_SH_CALC: begin
        w_j_nxt     = r_j + r_si + w_key_byte;
        w_state_nxt = ST_SH_RD_J;
      end
      ST_SH_RD_J: begin
        if (w_ack) begin
          w_sj_nxt    = mem_out;
          w_state_nxt = ST_SH_WR_J;
        end
      end
      ST_SH_WR_J: begin
        if (w_ack) begin
          w_state_nxt = ST_SH_WR_I;
        end
      end
      ST_SH_WR_I: begin
        if (w_ack) begin
          w_state_nxt = ST_SH_NEXT;
        end
      end
      ST_SH_NEXT: begin
        w_kidx_nxt = (r_kidx == KIDX_LAST) ? '0 : r_kidx + KIDX_W'(1);
        if (r_i == LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_i_nxt     = r_i + 8'd1;
          w_state_nxt = ST_SH_RD_I;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Port values are decoded from the state being entered so they are registered on entry.
  always_comb begin
    w_addr_nxt   = r_mem_address;
    w_data_nxt   = r_mem_data;
    w_wren_nxt   = 1'b0;
    w_busy_nxt   = 1'b1;
    w_t_done_nxt = 1'b0;
    case (w_state_nxt)
      ST_IDLE: begin
        w_busy_nxt = 1'b0;
      end
      ST_INIT_WR: begin
        w_addr_nxt = w_i_nxt;
        w_data_nxt = w_i_nxt;
        w_wren_nxt = 1'b1;
      end
      ST_SH_RD_I: begin
        w_addr_nxt = w_i_nxt;
      end
      ST_SH_RD_J: begin
        w_addr_nxt = w_j_nxt;
      end
      ST_SH_WR_J: begin
        w_addr_nxt = w_j_nxt;
        w_data_nxt = w_si_nxt;
        w_wren_nxt = 1'b1;
      end
      ST_SH_WR_I: begin
        w_addr_nxt = w_i_nxt;
        w_data_nxt = w_sj_nxt;
        w_wren_nxt = 1'b1;
      end
      ST_DONE: begin
        w_busy_nxt   = 1'b0;
        w_t_done_nxt = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i           <= '0;
      r_j           <= '0;
      r_si          <= '0;
      r_sj          <= '0;
      r_kidx        <= '0;
      r_mem_address <= '0;
      r_mem_data    <= '0;
      r_wren        <= 1'b0;
      r_busy        <= 1'b0;
      r_t_done      <= 1'b0;
    end else begin
      r_i           <= w_i_nxt;
      r_j           <= w_j_nxt;
      r_si          <= w_si_nxt;
      r_sj          <= w_sj_nxt;
      r_kidx        <= w_kidx_nxt;
      r_mem_address <= w_addr_nxt;
      r_mem_data    <= w_data_nxt;
      r_wren        <= w_wren_nxt;
      r_busy        <= w_busy_nxt;
      r_t_done      <= w_t_done_nxt;
    end
  end

  assign mem_address = r_mem_address;
  assign mem_data    = r_mem_data;
  assign wren        = r_wren;
  assign busy        = r_busy;
  assign t_done      = r_t_done;

endmodule

// File: tb/tb_rc4_ksa.sv
// Testbench for rc4_ksa: behavioural S-memory, reference RC4 model, and a t_done-driven
// scoreboard that checks latency, S contents, permutation property and PRGA keystream.
module tb_rc4_ksa;

  localparam int LATENCY    = 3585;
  localparam int BUDGET     = 4000;
  localparam int WRITE_HOLD = 2;

  typedef struct packed {
    logic [2047:0] s;
    logic [39:0]   prga;
    logic          chk_prga;
    logic [31:0]   exp_cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        sig_start;
  logic [23:0] secret_key;
  logic [7:0]  mem_out;
  logic [7:0]  mem_address;
  logic [7:0]  mem_data;
  logic        wren;
  logic        busy;
  logic        t_done;

  rc4_ksa dut (
    .clk         (clk),
    .reset       (reset),
    .sig_start   (sig_start),
    .secret_key  (secret_key),
    .mem_out     (mem_out),
    .mem_address (mem_address),
    .mem_data    (mem_data),
    .wren        (wren),
    .busy        (busy),
    .t_done      (t_done)
  );

  always #5 clk = ~clk;

  // Synchronous 256x8 S-memory, one-cycle read latency.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (wren) mem[mem_address] <= mem_data;
    mem_out <= mem[mem_address];
  end

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  int   prot_err = 0;
  int   run_len = 0;
  logic chk_low = 1'b0;
  logic prev_wren = 1'b0;
  logic [7:0] prev_addr = 8'd0;
  logic [7:0] prev_data = 8'd0;
  exp_t sb_q[$];
  exp_t mon_e;
  logic [2047:0] mon_snap;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [2047:0] ksa_model(input logic [23:0] key);
    logic [7:0]    s [256];
    logic [7:0]    kb [3];
    logic [7:0]    j;
    logic [7:0]    t;
    logic [2047:0] p;
    kb[0] = key[23:16];
    kb[1] = key[15:8];
    kb[2] = key[7:0];
    for (int k = 0; k < 256; k++) s[k] = 8'(k);
    j = 8'd0;
    for (int k = 0; k < 256; k++) begin
      j    = j + s[k] + kb[k % 3];
      t    = s[k];
      s[k] = s[j];
      s[j] = t;
    end
    for (int k = 0; k < 256; k++) p[8*k +: 8] = s[k];
    return p;
  endfunction

  function automatic logic [2047:0] identity_s();
    logic [2047:0] p;
    for (int k = 0; k < 256; k++) p[8*k +: 8] = 8'(k);
    return p;
  endfunction

  function automatic logic [39:0] prga5(input logic [2047:0] p);
    logic [7:0]  s [256];
    logic [7:0]  i;
    logic [7:0]  j;
    logic [7:0]  t;
    logic [7:0]  x;
    logic [39:0] o;
    for (int k = 0; k < 256; k++) s[k] = p[8*k +: 8];
    i = 8'd0;
    j = 8'd0;
    o = '0;
    for (int n = 0; n < 5; n++) begin
      i    = i + 8'd1;
      j    = j + s[i];
      t    = s[i];
      s[i] = s[j];
      s[j] = t;
      x    = s[i] + s[j];
      o[39-8*n -: 8] = s[x];
    end
    return o;
  endfunction

  function automatic logic [2047:0] mem_snapshot();
    logic [2047:0] p;
    for (int k = 0; k < 256; k++) p[8*k +: 8] = mem[k];
    return p;
  endfunction

  function automatic int count_diff(input logic [2047:0] a, input logic [2047:0] b);
    int n = 0;
    for (int k = 0; k < 256; k++) if (a[8*k +: 8] !== b[8*k +: 8]) n++;
    return n;
  endfunction

  function automatic int perm_missing(input logic [2047:0] p);
    logic [255:0] seen = '0;
    int n = 0;
    for (int k = 0; k < 256; k++) seen[p[8*k +: 8]] = 1'b1;
    for (int k = 0; k < 256; k++) if (!seen[k]) n++;
    return n;
  endfunction

  // Monitor: write-hold protocol tracking and scoreboard pop on every t_done.
  always @(negedge clk) begin
    if (reset) begin
      prev_wren = 1'b0;
      run_len   = 0;
      chk_low   = 1'b0;
    end else begin
      if (wren && !busy) prot_err++;
      if (wren && prev_wren && mem_address == prev_addr && mem_data == prev_data) begin
        run_len++;
      end else begin
        if (prev_wren && (run_len % WRITE_HOLD) != 0) prot_err++;
        run_len = wren ? 1 : 0;
      end
      prev_wren = wren;
      prev_addr = mem_address;
      prev_data = mem_data;

      if (chk_low) begin
        check("t_done_single_pulse", 64'(t_done), 64'd0);
        chk_low = 1'b0;
      end else if (t_done) begin
        done_cnt++;
        chk_low = 1'b1;
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_t_done: got pulse at cycle %0d, expected none", cyc);
        end else begin
          mon_e    = sb_q.pop_front();
          mon_snap = mem_snapshot();
          check("latency_cycle", 64'(cyc), 64'(mon_e.exp_cyc));
          check("busy_at_done", 64'(busy), 64'd0);
          check("s_vs_model_bad_bytes", 64'(count_diff(mon_snap, mon_e.s)), 64'd0);
          check("s_perm_missing_values", 64'(perm_missing(mon_snap)), 64'd0);
          check("write_hold_violations", 64'(prot_err), 64'd0);
          if (mon_e.chk_prga) check("prga_keystream", 64'(prga5(mon_snap)), 64'(mon_e.prga));
        end
      end
    end
  end

  task automatic start_run(input logic [23:0] key, input logic chk, input logic [39:0] prga,
                           input logic expect_done);
    @(negedge clk);
    secret_key = key;
    sig_start  = 1'b1;
    if (expect_done)
      sb_q.push_back('{s: ksa_model(key), prga: prga, chk_prga: chk, exp_cyc: 32'(cyc + LATENCY)});
    @(negedge clk);
    sig_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got %0d runs pending after %0d cycles, expected 0", name,
               sb_q.size(), BUDGET);
      sb_q.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int d0;
    int n;
    reset      = 1'b1;
    sig_start  = 1'b0;
    secret_key = '0;
    for (int k = 0; k < 256; k++) mem[k] = 8'(k) ^ 8'h5A;
    repeat (3) @(negedge clk);
    check("reset_outputs", 64'({mem_address, mem_data, wren, busy, t_done}), 64'd0);
    reset = 1'b0;
    repeat (100) @(negedge clk);
    check("idle_100_outputs", 64'({mem_address, mem_data, wren, busy, t_done}), 64'd0);
    check("idle_100_done_count", 64'(done_cnt), 64'd0);

    // Abort right after the identity fill, before any swap write.
    d0 = done_cnt;
    start_run(24'h000000, 1'b0, 40'h0, 1'b0);
    repeat (513) @(negedge clk);
    do_reset();
    check("abort_after_init_identity", 64'(count_diff(mem_snapshot(), identity_s())), 64'd0);
    check("abort_outputs_cleared", 64'({mem_address, mem_data, wren, busy, t_done}), 64'd0);

    // Full run with key "Key" against the reference keystream.
    start_run(24'h4B6579, 1'b1, 40'hEB9F7781B7, 1'b1);
    wait_idle("key_run");

    // Reset at cycle 1000 of a run must suppress t_done.
    start_run(24'h4B6579, 1'b0, 40'h0, 1'b0);
    repeat (998) @(negedge clk);
    do_reset();
    repeat (3700) @(negedge clk);
    check("abort_1000_no_done", 64'(done_cnt - d0 - 1), 64'd0);

    // All-zero key: iteration 0 has j == i.
    start_run(24'h000000, 1'b0, 40'h0, 1'b1);
    wait_idle("zero_key_run");

    // Start pulsed while busy is ignored.
    d0 = done_cnt;
    start_run(24'h010203, 1'b0, 40'h0, 1'b1);
    repeat (2000) @(negedge clk);
    sig_start = 1'b1;
    @(negedge clk);
    sig_start = 1'b0;
    wait_idle("busy_start_run");
    repeat (3700) @(negedge clk);
    check("busy_start_single_done", 64'(done_cnt - d0), 64'd1);

    // Back-to-back: new start on the first IDLE cycle after t_done.
    start_run(24'hFFFFFF, 1'b0, 40'h0, 1'b1);
    n = 0;
    while (!t_done && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (!t_done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL b2b_first_done_timeout: got no t_done in %0d cycles, expected pulse", BUDGET);
    end
    start_run(24'h1A2B3C, 1'b0, 40'h0, 1'b1);
    wait_idle("b2b_run");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running at time limit, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
